// File: rtl/seq_shift_if.sv
// Request/response bundle for the sequential shifter: operands and start
// from the requester, busy/done/result back from the engine.
interface seq_shift_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) ();
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;

  modport master (
    output start, data_in, amt, mode,
    input  busy, done, data_out
  );

  modport slave (
    input  start, data_in, amt, mode,
    output busy, done, data_out
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine. Moves the operand by up to STEP bit
// positions per clock, counting the remaining distance down to zero.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; operands latched when start is seen
//   SHIFT | working register moves by min(STEP, cnt) every cycle
//   DONE  | result published, done pulsed for one cycle
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  seq_shift_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] data_out_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_init;
  logic [CNT_W-1:0] k;

  // k is never 0 for ROR (cnt < WIDTH there), so WIDTH-k stays in range.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] w,
                                                input logic [1:0]       m,
                                                input logic [CNT_W-1:0] n);
    case (m)
      M_LSR:   shift_by = w >> n;
      M_LSL:   shift_by = w << n;
      M_ASR:   shift_by = $unsigned($signed(w) >>> n);
      default: shift_by = (w >> n) | (w << (CNT_W'(WIDTH) - n));
    endcase
  endfunction

  // Starting distance: saturate at WIDTH for shifts, wrap for rotate.
  always_comb begin
    cnt_init = '0;
    if (bus.mode == M_ROR)
      cnt_init = CNT_W'(32'(bus.amt) % 32'(WIDTH));
    else if (32'(bus.amt) >= 32'(WIDTH))
      cnt_init = CNT_W'(WIDTH);
    else
      cnt_init = CNT_W'(bus.amt);
  end

  assign k = (cnt_q > CNT_W'(STEP)) ? CNT_W'(STEP) : cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next working-register / counter values.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.data_in;
          cnt_d   = cnt_init;
          state_d = (cnt_init == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = shift_by(work_q, mode_q, k);
        cnt_d  = cnt_q - k;
        if (cnt_q == k) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; data_out only moves on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= M_LSR;
      data_out_q <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      if (state_q == IDLE && bus.start) mode_q <= bus.mode;
      if (state_d == DONE && state_q != DONE) data_out_q <= work_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench: one engine with STEP=1 and one with STEP=4, both 8 bits.
module tb_seq_shift_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  localparam logic [7:0] D = 8'b10110110;

  seq_shift_if #(.WIDTH(8), .AMT_W(8)) if1 ();
  seq_shift_if #(.WIDTH(8), .AMT_W(8)) if4 ();

  seq_shift_unit #(.WIDTH(8), .AMT_W(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  seq_shift_unit #(.WIDTH(8), .AMT_W(8), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .bus(if4)
  );

  // Run one request on the chosen engine; lat = edges after the start edge
  // until done is seen (0 means done in the cycle right after acceptance).
  task automatic do_op(input bit sel, input logic [7:0] d, input logic [7:0] a,
                       input logic [1:0] m, output logic [7:0] res, output int lat);
    int guard = 0;
    while ((sel ? if4.busy : if1.busy) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    if (sel) begin
      if4.start = 1'b1; if4.data_in = d; if4.amt = a; if4.mode = m;
    end else begin
      if1.start = 1'b1; if1.data_in = d; if1.amt = a; if1.mode = m;
    end
    @(posedge clk); #1;
    if1.start = 1'b0;
    if4.start = 1'b0;
    lat = 0;
    while (!(sel ? if4.done : if1.done) && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = sel ? if4.data_out : if1.data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (if1.busy !== 1'b0) $display("FAIL reset_busy1 got %b want 0", if1.busy); else pass_cnt++;
    total_cnt++; if (if1.done !== 1'b0) $display("FAIL reset_done1 got %b want 0", if1.done); else pass_cnt++;
    total_cnt++; if (if1.data_out !== 8'h00) $display("FAIL reset_dout1 got %b want 00000000", if1.data_out); else pass_cnt++;
    total_cnt++; if (if4.busy !== 1'b0) $display("FAIL reset_busy4 got %b want 0", if4.busy); else pass_cnt++;
    total_cnt++; if (if4.done !== 1'b0) $display("FAIL reset_done4 got %b want 0", if4.done); else pass_cnt++;
    total_cnt++; if (if4.data_out !== 8'h00) $display("FAIL reset_dout4 got %b want 00000000", if4.data_out); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_shift();
    logic [7:0] r; int lat;
    do_op(1'b0, D, 8'd0, 2'b00, r, lat);
    total_cnt++; if (r !== 8'b10110110) $display("FAIL zero_res got %b want 10110110", r); else pass_cnt++;
    total_cnt++; if (lat !== 0) $display("FAIL zero_lat got %0d want 0", lat); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (if1.done !== 1'b0 || if1.busy !== 1'b0)
      $display("FAIL zero_pulse got done=%b busy=%b want 0 0", if1.done, if1.busy); else pass_cnt++;
  endtask

  task automatic test_basic_modes();
    logic [7:0] r; int lat;
    logic [7:0] amts [4] = '{8'd2, 8'd2, 8'd2, 8'd3};
    logic [1:0] mds  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [7:0] exps [4] = '{8'b00101101, 8'b11101101, 8'b11011000, 8'b11010110};
    int         lats [4] = '{2, 2, 2, 3};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, D, amts[i], mds[i], r, lat);
      total_cnt++; if (r !== exps[i]) $display("FAIL basic_res%0d got %b want %b", i, r, exps[i]); else pass_cnt++;
      total_cnt++; if (lat !== lats[i]) $display("FAIL basic_lat%0d got %0d want %0d", i, lat, lats[i]); else pass_cnt++;
    end
  endtask

  task automatic test_saturate_wrap();
    logic [7:0] r; int lat;
    logic [7:0] amts [4] = '{8'd9, 8'd200, 8'd11, 8'd8};
    logic [1:0] mds  [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [7:0] dats [4] = '{D, D, D, 8'h36};
    logic [7:0] exps [4] = '{8'h00, 8'hFF, 8'b11010110, 8'h00};
    int         lats [4] = '{8, 8, 3, 8};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, dats[i], amts[i], mds[i], r, lat);
      total_cnt++; if (r !== exps[i]) $display("FAIL sat_res%0d got %b want %b", i, r, exps[i]); else pass_cnt++;
      total_cnt++; if (lat !== lats[i]) $display("FAIL sat_lat%0d got %0d want %0d", i, lat, lats[i]); else pass_cnt++;
    end
  endtask

  task automatic test_step4();
    logic [7:0] r; int lat;
    logic [7:0] amts [4] = '{8'd5, 8'd8, 8'd3, 8'd200};
    logic [1:0] mds  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [7:0] exps [4] = '{8'b11000000, 8'b10110110, 8'b11110110, 8'h00};
    int         lats [4] = '{2, 0, 1, 2};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, D, amts[i], mds[i], r, lat);
      total_cnt++; if (r !== exps[i]) $display("FAIL step4_res%0d got %b want %b", i, r, exps[i]); else pass_cnt++;
      total_cnt++; if (lat !== lats[i]) $display("FAIL step4_lat%0d got %0d want %0d", i, lat, lats[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int guard = 0;
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = D; if1.amt = 8'd2; if1.mode = 2'b00;
    @(posedge clk); #1;
    if1.data_in = 8'hFF; if1.amt = 8'd0; if1.mode = 2'b01;
    while (!if1.done && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if1.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (if1.done) dones++;
      @(posedge clk); #1;
    end
    total_cnt++; if (dones !== 1) $display("FAIL hs_done_count got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (if1.data_out !== 8'b00101101) $display("FAIL hs_res got %b want 00101101", if1.data_out); else pass_cnt++;
    total_cnt++; if (if1.busy !== 1'b0) $display("FAIL hs_idle got busy=%b want 0", if1.busy); else pass_cnt++;
  endtask

  task automatic test_abort();
    int dones = 0;
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = D; if1.amt = 8'd9; if1.mode = 2'b01;
    @(posedge clk); #1;
    if1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (if1.busy !== 1'b1) $display("FAIL abort_busy_pre got %b want 1", if1.busy); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (if1.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", if1.busy); else pass_cnt++;
    total_cnt++; if (if1.data_out !== 8'h00) $display("FAIL abort_dout got %b want 00000000", if1.data_out); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (if1.done) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL abort_done got %0d pulses want 0", dones); else pass_cnt++;
  endtask

  initial begin
    if1.start = 1'b0; if1.data_in = '0; if1.amt = '0; if1.mode = '0;
    if4.start = 1'b0; if4.data_in = '0; if4.amt = '0; if4.mode = '0;
    test_reset();
    test_zero_shift();
    test_basic_modes();
    test_saturate_wrap();
    test_step4();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
